// File: rtl/aes_job_arbiter.sv
// rtl/aes_job_arbiter.sv - two-port round-robin job arbiter and sequencer for a shared AES core
//
// Ports:
//   HCLK, HRESETn            clock, asynchronous active-low reset
//   reqN_valid/ready         job handshake per requester (N = 0, 1)
//   reqN_data/key/encrypt    128-bit block, 128-bit key, direction (1 = encrypt)
//   core_data/key/encrypt    operands presented to the AES core
//   core_key_load            one-cycle key-expansion enable
//   core_start               one-cycle start pulse
//   core_done/core_result    completion strobe and result from the core
//   rsp_valid/ready          response handshake
//   rsp_id/data/err          requester index, result (0 on error), watchdog timeout flag
module aes_job_arbiter #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic         HCLK,
  input  logic         HRESETn,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [127:0] req0_data,
  input  logic [127:0] req0_key,
  input  logic         req0_encrypt,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [127:0] req1_data,
  input  logic [127:0] req1_key,
  input  logic         req1_encrypt,
  output logic [127:0] core_data,
  output logic [127:0] core_key,
  output logic         core_encrypt,
  output logic         core_key_load,
  output logic         core_start,
  input  logic         core_done,
  input  logic [127:0] core_result,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic         rsp_id,
  output logic [127:0] rsp_data,
  output logic         rsp_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    KEYLOAD = 2'd1,
    RUN     = 2'd2,
    RESP    = 2'd3
  } state_e;

  localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT);

  state_e       state_q, state_d;
  logic         ptr_q, ptr_d;
  logic         cache_vld_q, cache_vld_d;
  logic [127:0] key_q, key_d;
  logic [127:0] data_q, data_d;
  logic         enc_q, enc_d;
  logic         key_load_q, key_load_d;
  logic         start_q, start_d;
  logic [15:0]  cnt_q, cnt_d;
  logic         rsp_valid_q, rsp_valid_d;
  logic         id_q, id_d;
  logic [127:0] rsp_data_q, rsp_data_d;
  logic         rsp_err_q, rsp_err_d;

  logic         grant1;
  logic         accept;
  logic [127:0] sel_key;

  // Port 1 wins when it is the only requester, or when both request and
  // the round-robin pointer favours it.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || ptr_q);
    req0_ready = (state_q == IDLE) && req0_valid && !grant1;
    req1_ready = (state_q == IDLE) && grant1;
    accept     = req0_ready || req1_ready;
    sel_key    = grant1 ? req1_key : req0_key;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    cache_vld_d = cache_vld_q;
    key_d       = key_q;
    data_d      = data_q;
    enc_d       = enc_q;
    key_load_d  = 1'b0;
    start_d     = 1'b0;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    id_d        = id_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          data_d = grant1 ? req1_data : req0_data;
          enc_d  = grant1 ? req1_encrypt : req0_encrypt;
          id_d   = grant1;
          ptr_d  = !grant1;
          if (!cache_vld_q || (sel_key != key_q)) begin
            // The cache is refreshed at the accept edge so core_key already
            // carries the new key during the key-load cycle.
            key_d       = sel_key;
            cache_vld_d = 1'b1;
            key_load_d  = 1'b1;
            state_d     = KEYLOAD;
          end else begin
            start_d = 1'b1;
            cnt_d   = 16'd0;
            state_d = RUN;
          end
        end
      end

      KEYLOAD: begin
        start_d = 1'b1;
        cnt_d   = 16'd0;
        state_d = RUN;
      end

      RUN: begin
        // core_done is ignored during the start cycle itself.
        if (!start_q && core_done) begin
          rsp_data_d  = core_result;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (cnt_q == TIMEOUT_W) begin
          // A hung core may have a corrupt key schedule: force a reload.
          rsp_data_d  = 128'd0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          cache_vld_d = 1'b0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      ptr_q       <= 1'b0;
      cache_vld_q <= 1'b0;
      key_q       <= 128'd0;
      data_q      <= 128'd0;
      enc_q       <= 1'b0;
      key_load_q  <= 1'b0;
      start_q     <= 1'b0;
      cnt_q       <= 16'd0;
      rsp_valid_q <= 1'b0;
      id_q        <= 1'b0;
      rsp_data_q  <= 128'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cache_vld_q <= cache_vld_d;
      key_q       <= key_d;
      data_q      <= data_d;
      enc_q       <= enc_d;
      key_load_q  <= key_load_d;
      start_q     <= start_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      id_q        <= id_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign core_data     = data_q;
  assign core_key      = key_q;
  assign core_encrypt  = enc_q;
  assign core_key_load = key_load_q;
  assign core_start    = start_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_id        = id_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;

endmodule

// File: doc/aes_job_arbiter.md
# aes_job_arbiter

Two-port job arbiter and sequencer for the shared AES combinational core. Two requesters (e.g. AHB slave front-end and DMA channel) submit 128-bit block/key/direction jobs over valid/ready. The block arbitrates round-robin, loads the key only when it differs from the cached key, starts the core, waits for completion with a watchdog, and returns the tagged result on a single response channel.

## Interface

- TIMEOUT, 64: max cycles to wait for `core_done` after `core_start`; range 2..65535.
- HCLK  in  1  clock; all state on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- req0_valid, req1_valid  in  1  job request valid.
- req0_ready, req1_ready  out  1  job accepted when valid&ready at the edge.
- req0_data, req1_data  in  128  plaintext/ciphertext block.
- req0_key, req1_key  in  128  key.
- req0_encrypt, req1_encrypt  in  1  1 = encrypt, 0 = decrypt.
- core_data  out  128  block to core; held from accept until RESP exit.
- core_key  out  128  key to core; holds the cached key.
- core_encrypt  out  1  direction to core.
- core_key_load  out  1  one-cycle key-expansion enable.
- core_start  out  1  one-cycle start pulse.
- core_done  in  1  core result valid.
- core_result  in  128  core output.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_id  out  1  requester index of response.
- rsp_data  out  128  result; 0 on error.
- rsp_err  out  1  1 = watchdog timeout.

## Operation

- States: IDLE, KEYLOAD, RUN, RESP.
- IDLE: `reqN_ready` combinational: if only one valid, that one ready; if both valid, port selected by priority pointer `ptr`. At the accepting edge latch data, key, encrypt, id; `ptr` <= other port. Next: KEYLOAD if cache invalid or latched key != cached key, else RUN.
- KEYLOAD (1 cycle): `core_key_load`=1, `core_key`=new key (cached key register updated at accept edge; cache valid set). Next: RUN.
- RUN: first cycle `core_start`=1, watchdog counter cleared. `core_done` sampled only from the cycle after start. On `core_done`: capture `core_result`, err=0, -> RESP. If counter reaches TIMEOUT with no done: data=0, err=1, cache invalidated, -> RESP.
- RESP: `rsp_valid`=1 with stable `rsp_id`, `rsp_data`, `rsp_err`; on `rsp_valid&rsp_ready` -> IDLE. `reqN_ready`=0 in all states except IDLE.
- `core_done` outside RUN ignored. `core_data`/`core_encrypt` unchanged outside accept.
- Reset: state IDLE, `ptr`=0, cache invalid, all outputs 0 (`core_key`, `core_data`, `rsp_data` = 0).
- Reset mid-operation: job discarded, no response issued.

## Timing

- Accept edge = E0. Key miss: KEYLOAD cycle E0..E1, `core_start` E1..E2. Key hit: `core_start` E0..E1.
- Core done at cycle D (≥ start+1) -> `rsp_valid` high from next edge.
- Min accept-to-rsp_valid: 2 cycles (hit), 3 cycles (miss).
- Timeout: `rsp_valid` asserts TIMEOUT+1 cycles after `core_start` cycle.
- Back-to-back: next accept no earlier than the cycle after RESP handshake (one IDLE cycle).
- Fairness: with both requesters permanently valid, grants alternate 0,1,0,1.

## Test plan

- Reset, req0 job key=000102..0f, data=00112233..ff, encrypt=1; core model done 1 cycle after start with 69c4e0d8..70b4c55a -> `core_key_load` one cycle, `core_start` next, `rsp_valid` 3 cycles after accept, `rsp_id`=0, `rsp_err`=0.
- Second req0 job same key -> no `core_key_load`, `core_start` cycle after accept; different key next -> key load reoccurs.
- req0 and req1 valid same cycle after reset -> req0 granted first, req1 second; then both re-valid -> req1-after-req0 order continues alternating.
- Core never asserts done, TIMEOUT=8 -> `rsp_valid` 9 cycles after start, `rsp_err`=1, `rsp_data`=0; next job with same key reloads key.
- `rsp_ready` low 5 cycles in RESP -> `rsp_*` stable, both `reqN_ready`=0, completion on 6th cycle.
- HRESETn low during RUN -> all outputs 0 immediately, no response; following job treated as key miss.
